vload_sequencer: RTL and testbench

//  Sequences strided vector loads from the 4-read-port data memory (dmem) into one vector value.

---
 rtl/vload_sequencer.sv | 141 ++++++++++++++
 tb/tb_vload_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vload_sequencer.sv
// Strided vector load sequencer: walks four dmem read lanes over ceil(count/4) beats
// and gathers the returned words into one VLEN-element vector.
module vload_sequencer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned VLEN      = 16,
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [31:0]              base,
    input  logic [31:0]              stride,
    input  logic [$clog2(VLEN):0]    count,
    output logic [31:0]              addr1,
    output logic [31:0]              addr2,
    output logic [31:0]              addr3,
    output logic [31:0]              addr4,
    input  logic [DATA_W-1:0]        rdata1,
    input  logic [DATA_W-1:0]        rdata2,
    input  logic [DATA_W-1:0]        rdata3,
    input  logic [DATA_W-1:0]        rdata4,
    output logic [VLEN*DATA_W-1:0]   vdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned CW = $clog2(VLEN) + 1;
    localparam int unsigned BW = (VLEN / 4 > 1) ? $clog2(VLEN / 4) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e                state_q;
    logic [31:0]           lane_q [4];
    logic [31:0]           step_q;
    logic [3:0]            act_q;
    logic [CW-1:0]         rem_q;
    logic [BW-1:0]         beat_q;
    logic [VLEN*DATA_W-1:0] vdata_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic [DATA_W-1:0]     rdata [4];
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         rem_nxt;
    logic [3:0]            act_init;
    logic [3:0]            act_nxt;
    logic [3:0]            oor;

    assign rdata[0] = rdata1;
    assign rdata[1] = rdata2;
    assign rdata[2] = rdata3;
    assign rdata[3] = rdata4;

    always_comb begin
        cnt     = (count > CW'(VLEN)) ? CW'(VLEN) : count;
        rem_nxt = (rem_q > CW'(4)) ? rem_q - CW'(4) : '0;
        for (int i = 0; i < 4; i++) begin
            act_init[i] = cnt > CW'(i);
            act_nxt[i]  = rem_nxt > CW'(i);
            oor[i]      = act_q[i] && (lane_q[i] >= 32'(MEM_DEPTH));
        end
    end

    // act_q is only non-zero in LOAD, so idle/done lanes naturally drive 0
    assign addr1 = act_q[0] ? lane_q[0] : '0;
    assign addr2 = act_q[1] ? lane_q[1] : '0;
    assign addr3 = act_q[2] ? lane_q[2] : '0;
    assign addr4 = act_q[3] ? lane_q[3] : '0;

    assign vdata = vdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            for (int i = 0; i < 4; i++) lane_q[i] <= '0;
            step_q  <= '0;
            act_q   <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            vdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        // lane offsets 0, s, 2s, 3s built from shifts and adds
                        lane_q[0] <= base;
                        lane_q[1] <= base + stride;
                        lane_q[2] <= base + (stride << 1);
                        lane_q[3] <= base + (stride << 1) + stride;
                        step_q    <= stride << 2;
                        rem_q     <= cnt;
                        act_q     <= act_init;
                        beat_q    <= '0;
                        vdata_q   <= '0;
                        err_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        if (cnt != '0) begin
                            state_q <= StLoad;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    for (int e = 0; e < int'(VLEN); e++) begin
                        if (beat_q == BW'(e / 4) && act_q[e % 4]) begin
                            vdata_q[e*DATA_W +: DATA_W] <= oor[e % 4] ? '0 : rdata[e % 4];
                        end
                    end
                    if (|oor) err_q <= 1'b1;
                    for (int i = 0; i < 4; i++) lane_q[i] <= lane_q[i] + step_q;
                    rem_q  <= rem_nxt;
                    beat_q <= beat_q + 1'b1;
                    if (rem_nxt == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        act_q   <= '0;
                    end else begin
                        act_q <= act_nxt;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vload_sequencer.sv
// Self-checking bench for vload_sequencer: combinational dmem model plus a
// closed-form reference (address = base + e*stride) for trace, vector, err and latency.
module tb_vload_sequencer;

    localparam int DW  = 32;
    localparam int VL  = 16;
    localparam int MD  = 1024;

    logic              clk = 1'b0;
    logic              rst, start;
    logic [31:0]       base, stride;
    logic [4:0]        count;
    logic [31:0]       addr1, addr2, addr3, addr4;
    logic [31:0]       rdata1, rdata2, rdata3, rdata4;
    logic [VL*DW-1:0]  vdata;
    logic              busy, done, err;

    logic [31:0] ram [0:MD-1];

    int n_cmp = 0;
    int n_bad = 0;

    // observations of one transaction
    logic [31:0] obs_addr [0:63];
    int          obs_n, done_at, busy_bad, done_addr_nz;
    logic        post_busy, post_done;

    // reference results
    logic [31:0]      exp_addr [0:63];
    int               exp_n, exp_done;
    logic [VL*DW-1:0] exp_vdata;
    logic             exp_err;

    vload_sequencer #(.DATA_W(DW), .VLEN(VL), .MEM_DEPTH(MD)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .stride(stride), .count(count),
        .addr1(addr1), .addr2(addr2), .addr3(addr3), .addr4(addr4),
        .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3), .rdata4(rdata4),
        .vdata(vdata), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // out-of-range reads return non-zero junk so missing zeroing is visible
    assign rdata1 = (addr1 < MD) ? ram[addr1[9:0]] : {16'hBAD0, addr1[15:0]};
    assign rdata2 = (addr2 < MD) ? ram[addr2[9:0]] : {16'hBAD0, addr2[15:0]};
    assign rdata3 = (addr3 < MD) ? ram[addr3[9:0]] : {16'hBAD0, addr3[15:0]};
    assign rdata4 = (addr4 < MD) ? ram[addr4[9:0]] : {16'hBAD0, addr4[15:0]};

    task automatic model(input logic [31:0] b, input logic [31:0] s, input int c);
        int cn, nb;
        logic [31:0] a;
        cn = (c > VL) ? VL : c;
        nb = (cn + 3) / 4;
        exp_n = nb * 4;
        exp_done = nb + 1;
        exp_vdata = '0;
        exp_err = 1'b0;
        for (int e = 0; e < exp_n; e++) begin
            a = b + 32'(e) * s;
            exp_addr[e] = (e < cn) ? a : 32'd0;
            if (e < cn) begin
                if (a < MD) exp_vdata[e*DW +: DW] = ram[a[9:0]];
                else exp_err = 1'b1;
            end
        end
    endtask

    // Called just after a negedge with the DUT idle; returns just after a negedge.
    task automatic issue(input logic [31:0] b, input logic [31:0] s, input logic [4:0] c);
        base = b; stride = s; count = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        obs_n = 0; done_at = 0; busy_bad = 0; done_addr_nz = 0;
        for (int n = 1; n <= 40 && done_at == 0; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                done_at = n;
                if ((addr1 | addr2 | addr3 | addr4) != 32'd0) done_addr_nz++;
            end else if (obs_n < 60) begin
                obs_addr[obs_n]   = addr1;
                obs_addr[obs_n+1] = addr2;
                obs_addr[obs_n+2] = addr3;
                obs_addr[obs_n+3] = addr4;
                obs_n += 4;
            end
        end
        @(negedge clk);
        post_busy = busy;
        post_done = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; base = 32'd5; stride = 32'd1; count = 5'd4;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_vs_start busy got %b want 0", busy);
        end
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, err} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags busy/done/err got %b want 000", {busy, done, err});
        end
        n_cmp++;
        if (vdata !== '0) begin
            n_bad++; $display("FAIL reset_vdata got %h want 0", vdata);
        end
        n_cmp++;
        if ((addr1 | addr2 | addr3 | addr4) !== 32'd0) begin
            n_bad++; $display("FAIL reset_addr got %h %h %h %h want 0", addr1, addr2, addr3, addr4);
        end
    endtask

    task automatic test_directed();
        logic [31:0] tb_b [6] = '{32'd0, 32'd10, 32'd20, 32'd1020, 32'd0, 32'd0};
        logic [31:0] tb_s [6] = '{32'd1, 32'd3, 32'hFFFF_FFFE, 32'd2, 32'd1, 32'd1};
        logic [4:0]  tb_c [6] = '{5'd16, 5'd6, 5'd4, 5'd4, 5'd0, 5'd31};
        int          tb_l [6] = '{5, 3, 2, 2, 1, 5};
        for (int i = 0; i < MD; i++) ram[i] = 32'(i) + 32'h100;
        for (int t = 0; t < 6; t++) begin
            model(tb_b[t], tb_s[t], int'(tb_c[t]));
            issue(tb_b[t], tb_s[t], tb_c[t]);
            n_cmp++;
            if (done_at !== tb_l[t]) begin
                n_bad++; $display("FAIL dir%0d done_cycle got %0d want %0d", t, done_at, tb_l[t]);
            end
            n_cmp++;
            if (obs_n !== exp_n) begin
                n_bad++; $display("FAIL dir%0d beats got %0d want %0d", t, obs_n / 4, exp_n / 4);
            end
            for (int j = 0; j < exp_n && j < obs_n; j++) begin
                n_cmp++;
                if (obs_addr[j] !== exp_addr[j]) begin
                    n_bad++;
                    $display("FAIL dir%0d addr[%0d] got %h want %h", t, j, obs_addr[j], exp_addr[j]);
                end
            end
            n_cmp++;
            if (vdata !== exp_vdata) begin
                n_bad++; $display("FAIL dir%0d vdata got %h want %h", t, vdata, exp_vdata);
            end
            n_cmp++;
            if (err !== exp_err) begin
                n_bad++; $display("FAIL dir%0d err got %b want %b", t, err, exp_err);
            end
            n_cmp++;
            if (busy_bad !== 0 || post_busy !== 1'b0 || post_done !== 1'b0 || done_addr_nz !== 0) begin
                n_bad++;
                $display("FAIL dir%0d handshake busy_gaps=%0d post_busy=%b post_done=%b done_addr=%0d want 0/0/0/0",
                         t, busy_bad, post_busy, post_done, done_addr_nz);
            end
            if (t == 0) begin
                n_cmp++;
                if (vdata[7*DW +: DW] !== 32'h107) begin
                    n_bad++; $display("FAIL dir0 elem7 got %h want 00000107", vdata[7*DW +: DW]);
                end
            end
            if (t == 3) begin
                n_cmp++;
                if (vdata[1*DW +: DW] !== 32'h4FE || vdata[2*DW +: DW] !== 32'd0 || err !== 1'b1) begin
                    n_bad++;
                    $display("FAIL dir3 elem1/elem2/err got %h/%h/%b want 000004fe/00000000/1",
                             vdata[1*DW +: DW], vdata[2*DW +: DW], err);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] b, s;
        logic [4:0]  c;
        for (int i = 0; i < MD; i++) ram[i] = $urandom;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, MD - 1));
                1: b = 32'($urandom_range(MD - 24, MD - 1));
                2: b = $urandom;
                default: b = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 3) == 0) s = $urandom;
            else s = 32'($urandom_range(0, 16)) - 32'd8;
            c = 5'($urandom_range(0, 31));
            model(b, s, int'(c));
            issue(b, s, c);
            n_cmp++;
            if (done_at !== exp_done) begin
                n_bad++; $display("FAIL rnd%0d done_cycle got %0d want %0d", it, done_at, exp_done);
            end
            n_cmp++;
            if (obs_n !== exp_n) begin
                n_bad++; $display("FAIL rnd%0d beats got %0d want %0d", it, obs_n / 4, exp_n / 4);
            end
            for (int j = 0; j < exp_n && j < obs_n; j++) begin
                n_cmp++;
                if (obs_addr[j] !== exp_addr[j]) begin
                    n_bad++;
                    $display("FAIL rnd%0d addr[%0d] got %h want %h", it, j, obs_addr[j], exp_addr[j]);
                end
            end
            n_cmp++;
            if (vdata !== exp_vdata || err !== exp_err) begin
                n_bad++;
                $display("FAIL rnd%0d vdata/err got %h/%b want %h/%b", it, vdata, err, exp_vdata, exp_err);
            end
            n_cmp++;
            if (busy_bad !== 0 || post_busy !== 1'b0) begin
                n_bad++; $display("FAIL rnd%0d busy gaps=%0d post=%b want 0/0", it, busy_bad, post_busy);
            end
        end
    endtask

    task automatic test_abort();
        int pulses, waited;
        for (int i = 0; i < MD; i++) ram[i] = 32'(i) + 32'h100;
        base = 32'd1020; stride = 32'd1; count = 5'd16; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (addr1 !== 32'd1020) begin
            n_bad++; $display("FAIL abort_beat0 addr1 got %0d want 1020", addr1);
        end
        start = 1'b1; base = 32'd0; stride = 32'd5; count = 5'd4;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (addr1 !== 32'd1024 || addr4 !== 32'd1027) begin
            n_bad++; $display("FAIL abort_ignore_start addr1/addr4 got %0d/%0d want 1024/1027", addr1, addr4);
        end
        @(negedge clk);
        n_cmp++;
        if (addr1 !== 32'd1028 || err !== 1'b1) begin
            n_bad++; $display("FAIL abort_beat2 addr1/err got %0d/%b want 1028/1", addr1, err);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, err} !== 3'b000 || vdata !== '0 || addr1 !== 32'd0) begin
            n_bad++;
            $display("FAIL abort_cleared busy/done/err got %b vdata %h addr1 %0d want 000/0/0",
                     {busy, done, err}, vdata, addr1);
        end
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++; $display("FAIL abort_no_done got %0d pulses want 0", pulses);
        end
        // reset while in the done cycle must also clear the held result
        base = 32'd1023; stride = 32'd1; count = 5'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (done !== 1'b1 && waited < 20);
        n_cmp++;
        if (waited !== 2 || err !== 1'b1) begin
            n_bad++; $display("FAIL done_rst_setup cycles/err got %0d/%b want 2/1", waited, err);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, err} !== 3'b000 || vdata !== '0) begin
            n_bad++; $display("FAIL done_rst busy/done/err got %b vdata %h want 000/0", {busy, done, err}, vdata);
        end
        model(32'd0, 32'd1, 16);
        issue(32'd0, 32'd1, 5'd16);
        n_cmp++;
        if (done_at !== 5 || vdata !== exp_vdata || err !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_restart done/err got %0d/%b want 5/0 vdata %h want %h",
                     done_at, err, vdata, exp_vdata);
        end
    endtask

    task automatic test_back_to_back();
        model(32'd1018, 32'd3, 8);
        issue(32'd1018, 32'd3, 5'd8);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (vdata !== exp_vdata || err !== exp_err) begin
            n_bad++; $display("FAIL b2b_hold vdata/err got %h/%b want %h/%b", vdata, err, exp_vdata, exp_err);
        end
        model(32'd100, 32'hFFFF_FFFF, 13);
        issue(32'd100, 32'hFFFF_FFFF, 5'd13);
        model(32'd7, 32'd9, 10);
        issue(32'd7, 32'd9, 5'd10);
        n_cmp++;
        if (done_at !== exp_done || vdata !== exp_vdata || err !== exp_err) begin
            n_bad++;
            $display("FAIL b2b_second done/err got %0d/%b want %0d/%b vdata %h want %h",
                     done_at, err, exp_done, exp_err, vdata, exp_vdata);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base = '0; stride = '0; count = '0;
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
